// File: rtl/sram_bist_pkg.sv
// Shared encodings for the multi-channel SRAM BIST: pattern codes, FSM states and the
// LFSR polynomial used by the pseudo-random pattern.
package sram_bist_pkg;

    localparam logic [1:0] PAT_ADDR  = 2'd0;
    localparam logic [1:0] PAT_CHK   = 2'd1;
    localparam logic [1:0] PAT_CONST = 2'd2;
    localparam logic [1:0] PAT_LFSR  = 2'd3;

    // Right-shift Galois mask for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StSettle,
        StRead,
        StDrain,
        StDone
    } state_e;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/sram_bist_patgen.sv
// Data pattern generator, used once for write data and once for read-expected data.
// The LFSR pattern exists only when SRAM_BIST_LFSR_EN is defined; otherwise it aliases PAT_CONST.
module sram_bist_patgen
    import sram_bist_pkg::*;
#(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        pattern_i,
    input  logic [DATA_W-1:0] seed_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              load_i,
    input  logic              step_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] seed_q, seed_d;
    logic [DATA_W-1:0] lfsr_data;

    always_comb begin
        seed_d = load_i ? seed_i : seed_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seed_q <= '0;
        end else begin
            seed_q <= seed_d;
        end
    end

`ifdef SRAM_BIST_LFSR_EN
    logic [31:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = 32'(seed_i);
            if (lfsr_d == '0) begin
                lfsr_d = 32'd1;
            end
        end else if (step_i) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_data = DATA_W'(lfsr_q);
`else
    logic unused_step;
    assign unused_step = step_i;
    assign lfsr_data   = seed_q;
`endif

    always_comb begin
        unique case (pattern_i)
            PAT_ADDR:  data_o = DATA_W'(addr_i);
            PAT_CHK:   data_o = addr_i[0] ? ~seed_q : seed_q;
            PAT_CONST: data_o = seed_q;
            PAT_LFSR:  data_o = lfsr_data;
        endcase
    end

endmodule

// File: rtl/sram_bist.sv
// Multi-channel SRAM BIST: write a pattern over [addr_lo, addr_hi] on all channels in lockstep,
// switch to read mode, read back and compare. Build option: SRAM_BIST_LFSR_EN enables pattern 3.
module sram_bist
    import sram_bist_pkg::*;
#(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned ADDR_W     = 18,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned ERR_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [1:0]               pattern,
    input  logic [DATA_W-1:0]        seed,
    input  logic [ADDR_W-1:0]        addr_lo,
    input  logic [ADDR_W-1:0]        addr_hi,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic                     cfg_err,
    output logic [NUM_CH*ERR_W-1:0]  err_cnt,
    output logic [NUM_CH*ADDR_W-1:0] first_err_addr,
    output logic                     tx_mode,
    output logic [NUM_CH-1:0]        wr_valid,
    input  logic [NUM_CH-1:0]        wr_ready,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic [NUM_CH*DATA_W-1:0] rd_data
);

    state_e                          state_q, state_d;
    logic [1:0]                      pattern_q, pattern_d;
    logic [ADDR_W-1:0]               lo_q, lo_d, hi_q, hi_d, addr_q, addr_d;
    logic [NUM_CH-1:0]               acc_q, acc_d;
    logic [7:0]                      cnt_q, cnt_d;
    logic                            cfg_err_q, cfg_err_d;
    logic [RD_LAT-1:0]               pv_q, pv_d;
    logic [RD_LAT-1:0][ADDR_W-1:0]   pa_q, pa_d;
    logic [RD_LAT-1:0][DATA_W-1:0]   pe_q, pe_d;
    logic [NUM_CH-1:0][ERR_W-1:0]    err_q, err_d;
    logic [NUM_CH-1:0][ADDR_W-1:0]   first_q, first_d;
    logic                            start_ok, wr_step, rd_step, err_none;
    logic [DATA_W-1:0]               wr_pat, rd_pat;

    sram_bist_patgen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wr_pat (
        .clk       (clk),
        .rst       (rst),
        .pattern_i (pattern_q),
        .seed_i    (seed),
        .addr_i    (addr_q),
        .load_i    (start_ok),
        .step_i    (wr_step),
        .data_o    (wr_pat)
    );

    sram_bist_patgen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rd_pat (
        .clk       (clk),
        .rst       (rst),
        .pattern_i (pattern_q),
        .seed_i    (seed),
        .addr_i    (addr_q),
        .load_i    (start_ok),
        .step_i    (rd_step),
        .data_o    (rd_pat)
    );

    assign wr_valid = (state_q == StWrite) ? ~acc_q : '0;

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        addr_d    = addr_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        cfg_err_d = cfg_err_q;
        start_ok  = 1'b0;
        wr_step   = 1'b0;
        rd_step   = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    start_ok  = 1'b1;
                    pattern_d = pattern;
                    lo_d      = addr_lo;
                    hi_d      = addr_hi;
                    addr_d    = addr_lo;
                    acc_d     = '0;
                    cnt_d     = '0;
                    cfg_err_d = (addr_hi < addr_lo);
                    state_d   = (addr_hi < addr_lo) ? StDone : StWrite;
                end
            end
            StWrite: begin
                acc_d = acc_q | (wr_valid & wr_ready);
                if (&acc_d) begin
                    acc_d = '0;
                    if (addr_q == hi_q) begin
                        state_d = StSettle;
                        cnt_d   = '0;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        wr_step = 1'b1;
                    end
                end
            end
            StSettle: begin
                if (cnt_q == 8'(SETTLE_CYC - 1)) begin
                    state_d = StRead;
                    addr_d  = lo_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StRead: begin
                if (addr_q == hi_q) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    rd_step = 1'b1;
                end
            end
            StDrain: begin
                if (cnt_q == 8'(RD_LAT - 1)) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Expected data travels alongside the read address so the compare lines up with rd_data.
    always_comb begin
        pv_d    = pv_q;
        pa_d    = pa_q;
        pe_d    = pe_q;
        pv_d[0] = (state_q == StRead);
        pa_d[0] = addr_q;
        pe_d[0] = rd_pat;
        for (int i = 1; i < RD_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pa_d[i] = pa_q[i-1];
            pe_d[i] = pe_q[i-1];
        end
    end

    always_comb begin
        err_d   = err_q;
        first_d = first_q;
        if (start_ok) begin
            err_d   = '0;
            first_d = '0;
        end else if (pv_q[RD_LAT-1]) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (rd_data[c*DATA_W +: DATA_W] != pe_q[RD_LAT-1]) begin
                    if (err_q[c] == '0) begin
                        first_d[c] = pa_q[RD_LAT-1];
                    end
                    if (err_q[c] != '1) begin
                        err_d[c] = err_q[c] + ERR_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        err_none = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (err_q[c] != '0) begin
                err_none = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pattern_q <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            addr_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            cfg_err_q <= 1'b0;
            pv_q      <= '0;
            pa_q      <= '0;
            pe_q      <= '0;
            err_q     <= '0;
            first_q   <= '0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            addr_q    <= addr_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            cfg_err_q <= cfg_err_d;
            pv_q      <= pv_d;
            pa_q      <= pa_d;
            pe_q      <= pe_d;
            err_q     <= err_d;
            first_q   <= first_d;
        end
    end

    assign busy           = (state_q == StWrite) || (state_q == StSettle) ||
                            (state_q == StRead) || (state_q == StDrain);
    assign tx_mode        = (state_q == StSettle) || (state_q == StRead) || (state_q == StDrain);
    assign done           = (state_q == StDone);
    assign pass           = done && !cfg_err_q && err_none;
    assign cfg_err        = cfg_err_q;
    assign err_cnt        = err_q;
    assign first_err_addr = first_q;
    assign wr_addr        = addr_q;
    assign rd_addr        = addr_q;
    assign wr_data        = wr_pat;

endmodule
